y86_regfile_param: RTL and testbench
====================================

// Module: y86_regfile_param
// PURPOSE
//  Parametrised register file for the y86-64 decode and write-back stages. It succeeds the fixed 15x64 decode_reg_block.
//  - Two combinational read ports (srcA/srcB -> valA/valB).
//  - Two synchronous write ports (dstE/valE, dstM/valM) with M-over-E priority.
//  - Sticky index-range error flag.
//  - Sequenced clear engine (IDLE/CLEAR FSM) that zeroes the file one register per cycle.
// PARAMETERS
//  WIDTH  64     data width of each register
//  NREGS  15     number of architectural registers (1..2**AW-1)
//  AW     4      register-index width
//  RNONE  4'hF   "no register" index; reads of it return 0, writes to it are dropped
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  srcA       in   AW     read index A
//  srcB       in   AW     read index B
//  valA       out  WIDTH  read data A (combinational)
//  valB       out  WIDTH  read data B (combinational)
//  we         in   1      global write enable for this cycle
//  dstE       in   AW     write index, E port
//  valE       in   WIDTH  write data, E port
//  dstM       in   AW     write index, M port
//  valM       in   WIDTH  write data, M port
//  clr_req    in   1      start a sequenced clear (1-cycle pulse or level)
//  busy       out  1      1 while the clear engine runs
//  reg_error  out  1      sticky flag: out-of-range index seen
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//  - All NREGS registers go to 0; busy=0; reg_error=0; FSM=IDLE; clear index=0.
//  Index classes:
//  - valid: idx < NREGS.
//  - none: idx == RNONE.
//  - bad: any other value.
//  Read (0-cycle latency):
//  - valX = regs[srcX] when srcX is valid; otherwise valX = 0 (none or bad).
//  Write (on rising clk, only when we=1 and busy=0):
//  - If dstE is valid: regs[dstE] <= valE.
//  - If dstM is valid: regs[dstM] <= valM.
//  - dstE==dstM (valid): the valM write wins.
//  - none or bad destination: that port's write is dropped.
//  - The new value is visible on valA/valB from the next cycle. Same-cycle reads return the old value (without the bypass feature).
//  Error:
//  - reg_error is set on rising clk if srcA or srcB is bad.
//  - It is also set if we=1 and dstE or dstM is bad.
//  - It stays set until reset. The clear engine does not reset it.
//  FSM:
//  - IDLE -> CLEAR when clr_req=1: busy=1 from the next cycle, clear index=0.
//  - CLEAR: each cycle regs[idx] <= 0, then idx++.
//  - When idx==NREGS-1, that register is cleared and the FSM returns to IDLE with busy=0 on the same edge.
//  - The full clear takes exactly NREGS cycles with busy=1.
//  - clr_req during CLEAR is ignored, with no restart and no queueing.
//  - Writes while busy=1 are dropped, not deferred.
//  - Reads during CLEAR return current contents, which may be partially cleared.
//  - Reset mid-CLEAR aborts to IDLE with all registers 0.
//  - A clr_req and a write in the same IDLE cycle: the write takes effect, then the clear starts.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//  - Write-to-read forwarding. When we=1, busy=0 and srcX is valid:
//    - valX = valM if srcX==dstM;
//    - else valX = valE if srcX==dstE;
//    - else regs[srcX].
//  - The priority mirrors the write priority. This adds a combinational path valE/valM -> valA/valB.
//  REGFILE_BYPASS_EN undefined:
//  - No forwarding. valX depends only on the register array and srcX.
// TESTING
//  1. Reset, then read all srcA=0..NREGS-1 -> valA=0; busy=0; reg_error=0.
//  2. we=1, dstE=4, valE=10, dstM=7, valM=12; next cycle srcA=4, srcB=7 -> valA=10, valB=12.
//  3. we=1, dstE=dstM=3, valE=114, valM=102 -> regs[3]=102. dstE=RNONE, valE=5 -> no register changes, reg_error=0.
//  4. Bench with NREGS=12: srcA=13 -> valA=0 and reg_error=1 after the edge; the flag persists after srcA=0; rst_n low clears it.
//  5. Load regs[0..14] with 1..15, pulse clr_req -> busy=1 for exactly 15 cycles.
//     - A write of 99 to reg 2 mid-clear is dropped; all regs=0 afterward.
//     - A second clr_req mid-clear has no effect on the duration.
//  6. REGFILE_BYPASS_EN: we=1, dstM=5, valM=52, srcA=5 -> valA=52 in the same cycle.
//     Without the macro: valA = old value, then 52 next cycle.
//     Also: rst_n low mid-clear -> busy=0 immediately, all regs 0.

Source files
------------

// File: rtl/y86_regfile_param.sv
// y86_regfile_param: parametrised y86-64 register file.
// Two combinational read ports, two synchronous write ports (M wins over E),
// a sticky out-of-range index flag and a sequenced clear engine.
// Optional feature: define REGFILE_BYPASS_EN for write-to-read forwarding.
module y86_regfile_param #(
    parameter int unsigned   WIDTH = 64,
    parameter int unsigned   NREGS = 15,
    parameter int unsigned   AW    = 4,
    parameter logic [AW-1:0] RNONE = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    srcA,
    input  logic [AW-1:0]    srcB,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    input  logic             we,
    input  logic [AW-1:0]    dstE,
    input  logic [WIDTH-1:0] valE,
    input  logic [AW-1:0]    dstM,
    input  logic [WIDTH-1:0] valM,
    input  logic             clr_req,
    output logic             busy,
    output logic             reg_error
);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_e;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             err_q, err_d;

    function automatic logic idx_valid(input logic [AW-1:0] idx);
        return 32'(idx) < NREGS;
    endfunction

    function automatic logic idx_bad(input logic [AW-1:0] idx);
        return !idx_valid(idx) && (idx != RNONE);
    endfunction

    assign busy      = (state_q == S_CLEAR);
    assign reg_error = err_q;

    // Read ports: zero for "none" and out-of-range indices
    always_comb begin
        valA = '0;
        valB = '0;
        if (idx_valid(srcA)) valA = regs_q[srcA];
        if (idx_valid(srcB)) valB = regs_q[srcB];
`ifdef REGFILE_BYPASS_EN
        if (we && !busy) begin
            if (idx_valid(srcA)) begin
                if (srcA == dstM)      valA = valM;
                else if (srcA == dstE) valA = valE;
            end
            if (idx_valid(srcB)) begin
                if (srcB == dstM)      valB = valM;
                else if (srcB == dstE) valB = valE;
            end
        end
`endif
    end

    // Next-state: writes, clear sequencing and sticky error flag
    always_comb begin
        regs_d  = regs_q;
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;

        if (idx_bad(srcA) || idx_bad(srcB) ||
            (we && (idx_bad(dstE) || idx_bad(dstM))))
            err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (we) begin
                    if (idx_valid(dstE)) regs_d[dstE] = valE;
                    // M is applied second so it wins on dstE == dstM
                    if (idx_valid(dstM)) regs_d[dstM] = valM;
                end
                if (clr_req) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                end
            end
            S_CLEAR: begin
                regs_d[idx_q] = '0;
                if (idx_q == AW'(NREGS - 1)) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
            state_q <= S_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_y86_regfile_param.sv
// tb_y86_regfile_param: randomized + directed bench for y86_regfile_param.
// Two instances (NREGS=15 and NREGS=12) share stimulus; each is compared
// against an array-based reference model.
module tb_y86_regfile_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valE, valM;
    logic        we, clr_req;
    logic [63:0] valA0, valB0, valA1, valB1;
    logic        busy0, busy1, err0, err1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    y86_regfile_param #(.WIDTH(64), .NREGS(15), .AW(4), .RNONE(4'hF)) u_dut (
        .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB),
        .valA(valA0), .valB(valB0), .we(we), .dstE(dstE), .valE(valE),
        .dstM(dstM), .valM(valM), .clr_req(clr_req), .busy(busy0),
        .reg_error(err0)
    );

    y86_regfile_param #(.WIDTH(64), .NREGS(12), .AW(4), .RNONE(4'hF)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB),
        .valA(valA1), .valB(valB1), .we(we), .dstE(dstE), .valE(valE),
        .dstM(dstM), .valM(valM), .clr_req(clr_req), .busy(busy1),
        .reg_error(err1)
    );

    // Reference model: plain arrays plus a remaining-cycles counter
    logic [63:0] mem [2][16];
    bit          mbusy [2];
    int          mleft [2];
    bit          merr  [2];

    function automatic int nr(input int k);
        return (k == 0) ? 15 : 12;
    endfunction

    function automatic bit vld(input int k, input logic [3:0] i);
        return int'(i) < nr(k);
    endfunction

    function automatic bit isbad(input int k, input logic [3:0] i);
        return !vld(k, i) && (i != 4'hF);
    endfunction

    function automatic logic [63:0] rd(input int k, input logic [3:0] s);
        if (!vld(k, s)) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (we && !mbusy[k]) begin
            if (s == dstM) return valM;
            if (s == dstE) return valE;
        end
`endif
        return mem[k][s];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) mem[k][i] = 64'd0;
            mbusy[k] = 1'b0;
            mleft[k] = 0;
            merr[k]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (isbad(k, srcA) || isbad(k, srcB) ||
                (we && (isbad(k, dstE) || isbad(k, dstM))))
                merr[k] = 1'b1;
            if (!mbusy[k]) begin
                if (we) begin
                    if (vld(k, dstE)) mem[k][dstE] = valE;
                    if (vld(k, dstM)) mem[k][dstM] = valM;
                end
                if (clr_req) begin
                    mbusy[k] = 1'b1;
                    mleft[k] = nr(k);
                end
            end else begin
                mem[k][nr(k) - mleft[k]] = 64'd0;
                mleft[k]--;
                if (mleft[k] == 0) mbusy[k] = 1'b0;
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1; checks outputs at negedge, advances model at posedge
    task automatic cycle();
        @(negedge clk);
        check_eq("valA0", valA0, rd(0, srcA));
        check_eq("valB0", valB0, rd(0, srcB));
        check_eq("valA1", valA1, rd(1, srcA));
        check_eq("valB1", valB1, rd(1, srcB));
        check_eq("busy0", 64'(busy0), 64'(mbusy[0]));
        check_eq("busy1", 64'(busy1), 64'(mbusy[1]));
        check_eq("err0", 64'(err0), 64'(merr[0]));
        check_eq("err1", 64'(err1), 64'(merr[1]));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_busy0", 64'(busy0), 64'd0);
        check_eq("rst_busy1", 64'(busy1), 64'd0);
        check_eq("rst_err0", 64'(err0), 64'd0);
        check_eq("rst_err1", 64'(err1), 64'd0);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; clr_req = 1'b0;
        srcA = 4'd0; srcB = 4'd0; dstE = 4'hF; dstM = 4'hF;
        valE = 64'd0; valM = 64'd0;
    endtask

    initial begin
        int cnt;
        int guard;
        logic [63:0] old5;

        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: all registers read zero after reset
        for (int i = 0; i < 15; i++) begin
            srcA = 4'(i);
            cycle();
            check_eq("t1_zero", valA0, 64'd0);
        end
        check_eq("t1_err0", 64'(err0), 64'd0);

        // 2: dual write then read back
        do_reset();
        we = 1'b1; dstE = 4'd4; valE = 64'd10; dstM = 4'd7; valM = 64'd12;
        cycle();
        idle_inputs();
        srcA = 4'd4; srcB = 4'd7;
        cycle();
        check_eq("t2_valA", valA0, 64'd10);
        check_eq("t2_valB", valB0, 64'd12);

        // 3: M wins on collision; RNONE write dropped without error
        we = 1'b1; dstE = 4'd3; dstM = 4'd3; valE = 64'd114; valM = 64'd102;
        cycle();
        we = 1'b1; dstE = 4'hF; valE = 64'd5; dstM = 4'hF; valM = 64'd5;
        cycle();
        idle_inputs();
        srcA = 4'd3; srcB = 4'd4;
        cycle();
        check_eq("t3_prio", valA0, 64'd102);
        check_eq("t3_keep", valB0, 64'd10);
        check_eq("t3_noerr", 64'(err0), 64'd0);

        // 4: out-of-range index on the 12-entry instance
        do_reset();
        srcA = 4'd13;
        #1;
        check_eq("t4_rd0", valA1, 64'd0);
        cycle();
        check_eq("t4_err", 64'(err1), 64'd1);
        srcA = 4'd0;
        cycle();
        check_eq("t4_sticky", 64'(err1), 64'd1);
        do_reset();
        check_eq("t4_rstclr", 64'(err1), 64'd0);

        // 5: sequenced clear, dropped write, ignored second request
        for (int i = 0; i < 15; i++) begin
            we = 1'b1; dstE = 4'(i); valE = 64'(i + 1); dstM = 4'hF;
            cycle();
        end
        idle_inputs();
        srcA = 4'd14;
        #1;
        check_eq("t5_load", valA0, 64'd15);
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        cnt = 0;
        guard = 0;
        while (busy0 && guard < 40) begin
            cnt++;
            guard++;
            srcA = 4'd2;
            if (cnt == 3) begin
                we = 1'b1; dstE = 4'd2; valE = 64'd99; dstM = 4'hF;
            end else begin
                we = 1'b0;
            end
            clr_req = (cnt == 5);
            cycle();
        end
        idle_inputs();
        check_eq("t5_len", 64'(cnt), 64'd15);
        for (int i = 0; i < 15; i++) begin
            srcA = 4'(i);
            cycle();
            check_eq("t5_zero", valA0, 64'd0);
        end

        // 6: same-cycle read of a register being written
        we = 1'b1; dstE = 4'd5; valE = 64'd7; dstM = 4'hF;
        cycle();
        old5 = 64'd7;
        we = 1'b1; dstE = 4'hF; dstM = 4'd5; valM = 64'd52; srcA = 4'd5;
        #3;
`ifdef REGFILE_BYPASS_EN
        check_eq("t6_same", valA0, 64'd52);
`else
        check_eq("t6_same", valA0, old5);
`endif
        cycle();
        idle_inputs();
        srcA = 4'd5;
        #1;
        check_eq("t6_next", valA0, 64'd52);

        // Reset in the middle of a clear
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check_eq("mid_busy", 64'(busy0), 64'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("midrst_busy", 64'(busy0), 64'd0);
        srcA = 4'd5; srcB = 4'd14;
        #1;
        check_eq("midrst_r5", valA0, 64'd0);
        check_eq("midrst_r14", valB0, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized phase against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            srcA    = 4'($urandom_range(0, 15));
            srcB    = 4'($urandom_range(0, 15));
            dstE    = 4'($urandom_range(0, 15));
            dstM    = ($urandom_range(0, 3) == 0) ? dstE : 4'($urandom_range(0, 15));
            valE    = {$urandom, $urandom};
            valM    = {$urandom, $urandom};
            we      = ($urandom_range(0, 3) != 0);
            clr_req = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
